ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide execute unit.
// Iterative shift-add multiply and restoring divide, 32 cycles per op.
module ex_muldiv_unit #(
    parameter logic [5:0] ID_MUL    = 6'd37,
    parameter logic [5:0] ID_MULH   = 6'd38,
    parameter logic [5:0] ID_MULHSU = 6'd39,
    parameter logic [5:0] ID_MULHU  = 6'd40,
    parameter logic [5:0] ID_DIV    = 6'd41,
    parameter logic [5:0] ID_DIVU   = 6'd42,
    parameter logic [5:0] ID_REM    = 6'd43,
    parameter logic [5:0] ID_REMU   = 6'd44
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  instr_id_in,
    input  logic [31:0] rs1_value_in,
    input  logic [31:0] rs2_value_in,
    input  logic [4:0]  rd_addr_in,
    input  logic        flush,
    output logic        stall_req,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  rd_addr_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    state_t      state_q;
    op_t         op_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        neg_q;
    logic [31:0] result_q;
    logic [4:0]  rd_q;

    logic        op_valid;
    op_t         op_dec;
    logic        sgn1, sgn2, neg_dec, div0, ovf, fast;
    logic [31:0] mag1, mag2, fast_res;
    logic [32:0] mul_sum, div_sh, div_diff;
    logic        div_ge;
    logic [63:0] acc_d, prod_s;
    logic [31:0] q_s, r_s, final_d;

    // Decode the incoming instr_id into an op.
    always_comb begin
        op_valid = 1'b1;
        op_dec   = OP_MUL;
        case (instr_id_in)
            ID_MUL:    op_dec = OP_MUL;
            ID_MULH:   op_dec = OP_MULH;
            ID_MULHSU: op_dec = OP_MULHSU;
            ID_MULHU:  op_dec = OP_MULHU;
            ID_DIV:    op_dec = OP_DIV;
            ID_DIVU:   op_dec = OP_DIVU;
            ID_REM:    op_dec = OP_REM;
            ID_REMU:   op_dec = OP_REMU;
            default:   op_valid = 1'b0;
        endcase
    end

    // Operand magnitudes, result sign and fast-path detection at accept.
    always_comb begin
        sgn1 = rs1_value_in[31] & (op_dec == OP_MULH || op_dec == OP_MULHSU
                                || op_dec == OP_DIV || op_dec == OP_REM);
        sgn2 = rs2_value_in[31] & (op_dec == OP_MULH || op_dec == OP_DIV
                                || op_dec == OP_REM);
        mag1 = sgn1 ? -rs1_value_in : rs1_value_in;
        mag2 = sgn2 ? -rs2_value_in : rs2_value_in;
        // Remainder follows the dividend; everything else is the sign product.
        neg_dec = (op_dec == OP_REM) ? sgn1 : (sgn1 ^ sgn2);
        div0 = op_dec[2] && (rs2_value_in == 32'h0);
        ovf  = (op_dec == OP_DIV || op_dec == OP_REM)
            && (rs1_value_in == 32'h8000_0000)
            && (rs2_value_in == 32'hFFFF_FFFF);
        fast = div0 | ovf;
        if (div0)
            fast_res = (op_dec == OP_DIV || op_dec == OP_DIVU)
                     ? 32'hFFFF_FFFF : rs1_value_in;
        else
            fast_res = (op_dec == OP_DIV) ? 32'h8000_0000 : 32'h0;
    end

    // One iteration step plus sign correction for the final cycle.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]}
                 + (acc_q[0] ? {1'b0, opnd_q} : 33'h0);
        div_sh   = {acc_q[63:32], acc_q[31]};
        div_diff = div_sh - {1'b0, opnd_q};
        div_ge   = ~div_diff[32];
        if (op_q[2])
            acc_d = {div_ge ? div_diff[31:0] : div_sh[31:0],
                     acc_q[30:0], div_ge};
        else
            acc_d = {mul_sum, acc_q[31:1]};
        prod_s = neg_q ? -acc_d : acc_d;
        q_s    = neg_q ? -acc_d[31:0] : acc_d[31:0];
        r_s    = neg_q ? -acc_d[63:32] : acc_d[63:32];
        case (op_q)
            OP_MUL:               final_d = prod_s[31:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:             final_d = prod_s[63:32];
            OP_DIV, OP_DIVU:      final_d = q_s;
            OP_REM, OP_REMU:      final_d = r_s;
            default:              final_d = 32'h0;
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= 6'd0;
            acc_q    <= 64'h0;
            opnd_q   <= 32'h0;
            neg_q    <= 1'b0;
            result_q <= 32'h0;
            rd_q     <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid && !flush) begin
                        op_q   <= op_dec;
                        neg_q  <= neg_dec;
                        rd_q   <= rd_addr_in;
                        cnt_q  <= 6'd0;
                        acc_q  <= {32'h0, op_dec[2] ? mag1 : mag2};
                        opnd_q <= op_dec[2] ? mag2 : mag1;
                        if (fast) begin
                            result_q <= fast_res;
                            state_q  <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        cnt_q   <= 6'd0;
                        state_q <= IDLE;
                    end else if (cnt_q == 6'd31) begin
                        acc_q    <= acc_d;
                        cnt_q    <= 6'd0;
                        result_q <= final_d;
                        state_q  <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs; reset masks the stall even with an op waiting.
    always_comb begin
        stall_req = ~rst & (((state_q == IDLE) & op_valid & ~flush)
                          | (state_q == CALC));
        result_valid = (state_q == DONE) & ~flush;
        result       = result_q;
        rd_addr_out  = rd_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M cases plus random traffic
// compared cycle by cycle against a transaction-level model.
module tb_ex_muldiv_unit;

    localparam logic [5:0] MUL = 6'd37, MULH = 6'd38, MULHSU = 6'd39;
    localparam logic [5:0] MULHU = 6'd40, DIV = 6'd41, DIVU = 6'd42;
    localparam logic [5:0] REM = 6'd43, REMU = 6'd44;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  instr = 6'd0;
    logic [31:0] a_in = 32'h0, b_in = 32'h0;
    logic [4:0]  rd_in = 5'd0;
    logic        flush = 1'b0;
    logic        stall_req, result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit dut (
        .clk(clk), .rst(rst), .instr_id_in(instr),
        .rs1_value_in(a_in), .rs2_value_in(b_in), .rd_addr_in(rd_in),
        .flush(flush), .stall_req(stall_req),
        .result_valid(result_valid), .result(result), .rd_addr_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit is_op(input logic [5:0] id);
        return id >= MUL && id <= REMU;
    endfunction

    function automatic bit is_fast(input logic [5:0] id,
                                   input logic [31:0] a, b);
        if (id >= DIV && id <= REMU && b == 32'h0) return 1'b1;
        if ((id == DIV || id == REM) && a == 32'h8000_0000
            && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    // Architectural RV32M result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_fn(input logic [5:0] id,
                                           input logic [31:0] a, b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (id)
            MUL:    begin p = ua * ub; return p[31:0]; end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Transaction model: an accepted op produces its result 32 edges
    // later (1 edge for the fast path); flush kills it; the strobe lasts
    // one cycle and the held instruction is not taken again that edge.
    bit          m_busy = 0, m_done = 0;
    int          m_left = 0;
    logic [31:0] m_res = 0, m_pend = 0;
    logic [4:0]  m_rd = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_left <= 0;
            m_res <= 0; m_rd <= 0;
        end else if (flush) begin
            m_busy <= 0; m_done <= 0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 0; m_done <= 1; m_res <= m_pend;
            end
            m_left <= m_left - 1;
        end else if (is_op(instr)) begin
            m_rd <= rd_in;
            if (is_fast(instr, a_in, b_in)) begin
                m_done <= 1; m_res <= ref_fn(instr, a_in, b_in);
            end else begin
                m_busy <= 1; m_left <= 32;
                m_pend <= ref_fn(instr, a_in, b_in);
            end
        end
    end

    // Compare process: outputs against the model every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("stall_req", stall_req,
                32'(m_busy || (!m_done && is_op(instr) && !flush)));
            chk("result_valid", result_valid, 32'(m_done && !flush));
            if (m_done && !flush) begin
                chk("result", result, m_res);
                chk("rd_addr_out", rd_out, 32'(m_rd));
            end
        end
    end

    // Issue one op (called at posedge+1) and wait, bounded, for its strobe.
    task automatic do_op(input logic [5:0] id, input logic [31:0] a, b,
                         input logic [4:0] rd, output logic [31:0] res,
                         output int lat, output int stalls, output bit got);
        instr = id; a_in = a; b_in = b; rd_in = rd;
        lat = 0; stalls = 0; got = 0; res = 32'h0;
        @(negedge clk);
        if (stall_req) stalls++;
        while (!got && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (stall_req) stalls++;
            if (result_valid) begin got = 1; res = result; end
        end
        @(posedge clk); #1;
        instr = 6'd0;
    endtask

    task automatic directed(input string name, input logic [5:0] id,
                            input logic [31:0] a, b,
                            input logic [31:0] exp, input int exp_lat);
        logic [31:0] r;
        int lat, st;
        bit got;
        do_op(id, a, b, 5'd7, r, lat, st, got);
        chk({name, " strobe"}, 32'(got), 32'd1);
        chk({name, " value"}, r, exp);
        chk({name, " latency"}, lat, exp_lat);
    endtask

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        int lat, st, nv;
        bit got;

        // Pin the model with hand-computed values.
        chk("model MUL", ref_fn(MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("model MULHSU", ref_fn(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
            32'hFFFF_FFFF);
        chk("model DIV", ref_fn(DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model REM", ref_fn(REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model REMU", ref_fn(REMU, 32'd100, 32'd3), 32'd1);

        // Reset state, with an op waiting on the inputs.
        instr = MUL; a_in = 32'd3; b_in = 32'd4; rd_in = 5'd1;
        #2;
        chk("reset stall", stall_req, 32'd0);
        chk("reset valid", result_valid, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset rd", rd_out, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // MUL right after reset release: 33 stall cycles, strobe after edge 33.
        do_op(MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, r, lat, st, got);
        chk("MUL strobe", 32'(got), 32'd1);
        chk("MUL value", r, 32'hFFFF_FFEB);
        chk("MUL latency", lat, 33);
        chk("MUL stall cycles", st, 33);

        directed("MULHU", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFE, 33);
        directed("MULHSU", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 33);
        directed("MULH", MULH, 32'hFFFF_FFFE, 32'h0000_0003,
                 32'hFFFF_FFFF, 33);
        directed("DIV", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        directed("REM", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        directed("DIVU by 0", DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
        directed("REMU by 0", REMU, 32'd100, 32'd0, 32'd100, 1);
        directed("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h8000_0000, 1);
        directed("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Flush during CALC iteration 10.
        instr = MUL; a_in = 32'd9; b_in = 32'd9; rd_in = 5'd2;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1; instr = 6'd0;
        @(negedge clk);
        chk("flush valid", result_valid, 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush stall after", stall_req, 32'd0);
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) nv++;
        end
        chk("flush no strobe", nv, 32'd0);
        @(posedge clk); #1;

        // Leave a non-zero result, then reset mid-CALC.
        directed("DIVU pre-rst", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        instr = MUL; a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0; rd_in = 5'd9;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst stall", stall_req, 32'd0);
        chk("midrst valid", result_valid, 32'd0);
        chk("midrst result", result, 32'd0);
        chk("midrst rd", rd_out, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        do_op(MUL, 32'd7, 32'hFFFF_FFFD, 5'd12, r, lat, st, got);
        chk("post-rst MUL strobe", 32'(got), 32'd1);
        chk("post-rst MUL value", r, 32'hFFFF_FFEB);
        chk("post-rst MUL latency", lat, 33);

        // Random traffic: new instruction whenever the pipe advances.
        repeat (3000) begin
            @(posedge clk); #1;
            flush = ($urandom_range(0, 99) < 3);
            if (!stall_req || flush) begin
                if ($urandom_range(0, 9) < 8)
                    instr = 6'($urandom_range(37, 44));
                else
                    instr = 6'($urandom_range(0, 36));
                a_in  = rval();
                b_in  = rval();
                rd_in = 5'($urandom_range(0, 31));
            end
        end
        @(posedge clk); #1 flush = 1'b0; instr = 6'd0;
        repeat (40) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
